// File: rtl/texture_buffer_db_if.sv
// Texture buffer bus: texture load stream, texel fetch request/response and load status.
`timescale 1ns/1ps
interface texture_buffer_db_if #(
    parameter int STREAM_WIDTH = 32
);
    logic [3:0]              confWidthLog2;
    logic [3:0]              confHeightLog2;
    logic                    confClampS;
    logic                    confClampT;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic                    s_axis_tlast;
    logic [STREAM_WIDTH-1:0] s_axis_tdata;
    logic                    texelValid;
    logic [15:0]             texelS;
    logic [15:0]             texelT;
    logic                    texelOutValid;
    logic [15:0]             texel;
    logic                    loadDone;
    logic                    overflow;
    logic                    activeBank;

    modport master (
        output confWidthLog2, confHeightLog2, confClampS, confClampT,
        output s_axis_tvalid, s_axis_tlast, s_axis_tdata,
        output texelValid, texelS, texelT,
        input  s_axis_tready, texelOutValid, texel, loadDone, overflow, activeBank
    );

    modport slave (
        input  confWidthLog2, confHeightLog2, confClampS, confClampT,
        input  s_axis_tvalid, s_axis_tlast, s_axis_tdata,
        input  texelValid, texelS, texelT,
        output s_axis_tready, texelOutValid, texel, loadDone, overflow, activeBank
    );
endinterface

// File: rtl/texture_buffer_db.sv
// Double-buffered texture buffer: the back bank is loaded from a stream while the
// front bank serves a fixed two-cycle texel read pipeline; banks swap after tlast.
`timescale 1ns/1ps
module texture_buffer_db #(
    parameter int STREAM_WIDTH = 32,
    parameter int SIZE         = 15,
    parameter int PIXEL_WIDTH  = 16
) (
    input logic               clk,
    input logic               reset,
    texture_buffer_db_if.slave bus
);
    localparam int PIX_PER_WORD   = STREAM_WIDTH / PIXEL_WIDTH;
    localparam int SUB_BITS       = $clog2(PIX_PER_WORD);
    localparam int PIX_ADDR_BITS  = SIZE - 2;
    localparam int WORD_ADDR_BITS = PIX_ADDR_BITS - SUB_BITS;
    localparam int BANK_WORDS     = 1 << WORD_ADDR_BITS;
    localparam int COUNT_BITS     = WORD_ADDR_BITS + 1;

    logic [STREAM_WIDTH-1:0]   mem [2*BANK_WORDS];

    logic                      tready;
    logic                      load_done;
    logic                      overflow_q;
    logic                      active_bank;
    logic [COUNT_BITS-1:0]     word_count;
    logic                      first_beat;
    logic                      swap_pending;
    logic [3:0]                pend_w, pend_h, act_w, act_h;
    logic                      pend_cs, pend_ct, act_cs, act_ct;

    logic                      beat;
    logic                      has_room;
    logic                      back_bank;

    logic [7:0]                s_idx, t_idx;
    logic [PIX_ADDR_BITS-1:0]  pix_addr;
    logic [WORD_ADDR_BITS-1:0] req_word;
    logic [1:0]                req_sub;

    logic                      s0_valid;
    logic                      s0_bank;
    logic [WORD_ADDR_BITS-1:0] s0_word;
    logic [1:0]                s0_sub;
    logic [STREAM_WIDTH-1:0]   rd_word;
    logic [PIXEL_WIDTH-1:0]    rd_pixel;
    logic                      texel_valid;
    logic [PIXEL_WIDTH-1:0]    texel_q;

    function automatic logic [3:0] clamp_log2(input logic [3:0] v);
        if (v < 4'd5)
            clamp_log2 = 4'd5;
        else if (v > 4'd8)
            clamp_log2 = 4'd8;
        else
            clamp_log2 = v;
    endfunction

    // Q1.14 coordinate to texel index on an axis of 2^n texels.
    function automatic logic [7:0] axis_index(input logic [15:0] coord, input logic [3:0] n,
                                              input logic clamp);
        logic [7:0] frac;
        logic [7:0] top;
        frac = 8'(coord[13:0] >> (4'd14 - n));
        top  = 8'hFF >> (4'd8 - n);
        if (clamp && coord[15])
            axis_index = '0;
        else if (clamp && coord[14])
            axis_index = top;
        else
            axis_index = frac;
    endfunction

    assign beat     = bus.s_axis_tvalid && tready;
    assign has_room = (word_count < COUNT_BITS'(BANK_WORDS));
    // While a swap is pending the bank just loaded is still the back bank;
    // a beat arriving then belongs to the other bank.
    assign back_bank = swap_pending ? active_bank : ~active_bank;

    assign bus.s_axis_tready = tready;
    assign bus.loadDone      = load_done;
    assign bus.overflow      = overflow_q;
    assign bus.activeBank    = active_bank;
    assign bus.texelOutValid = texel_valid;
    assign bus.texel         = texel_q;

    // Load control: word counting, config latch, overflow and bank swap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tready       <= 1'b0;
            load_done    <= 1'b0;
            overflow_q   <= 1'b0;
            active_bank  <= 1'b0;
            word_count   <= '0;
            first_beat   <= 1'b1;
            swap_pending <= 1'b0;
            pend_w       <= 4'd5;
            pend_h       <= 4'd5;
            pend_cs      <= 1'b0;
            pend_ct      <= 1'b0;
            act_w        <= 4'd5;
            act_h        <= 4'd5;
            act_cs       <= 1'b0;
            act_ct       <= 1'b0;
        end else begin
            tready       <= 1'b1;
            load_done    <= swap_pending;
            swap_pending <= 1'b0;
            if (swap_pending) begin
                active_bank <= ~active_bank;
                act_w       <= pend_w;
                act_h       <= pend_h;
                act_cs      <= pend_cs;
                act_ct      <= pend_ct;
            end
            if (beat) begin
                if (first_beat) begin
                    pend_w  <= clamp_log2(bus.confWidthLog2);
                    pend_h  <= clamp_log2(bus.confHeightLog2);
                    pend_cs <= bus.confClampS;
                    pend_ct <= bus.confClampT;
                end
                if (has_room)
                    word_count <= word_count + COUNT_BITS'(1);
                else
                    overflow_q <= 1'b1;
                if (bus.s_axis_tlast) begin
                    word_count   <= '0;
                    swap_pending <= 1'b1;
                    first_beat   <= 1'b1;
                end else begin
                    first_beat   <= 1'b0;
                end
            end
        end
    end

    // Back-bank write of accepted in-range beats.
    always_ff @(posedge clk) begin
        if (beat && has_room)
            mem[{back_bank, word_count[WORD_ADDR_BITS-1:0]}] <= bus.s_axis_tdata;
    end

    // Request address: per-axis index, pixel address, word and sub-pixel select.
    always_comb begin
        s_idx    = axis_index(bus.texelS, act_w, act_cs);
        t_idx    = axis_index(bus.texelT, act_h, act_ct);
        pix_addr = PIX_ADDR_BITS'(({8'd0, t_idx} << act_w) | {8'd0, s_idx});
        req_word = WORD_ADDR_BITS'(pix_addr >> SUB_BITS);
        req_sub  = 2'(pix_addr & PIX_ADDR_BITS'(PIX_PER_WORD - 1));
    end

    // RAM read and sub-pixel select from the captured bank/address.
    always_comb begin
        rd_word  = mem[{s0_bank, s0_word}];
        rd_pixel = PIXEL_WIDTH'(rd_word >> {s0_sub, 4'b0000});
    end

    // Read pipeline: capture request, then register the selected texel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_valid    <= 1'b0;
            s0_bank     <= 1'b0;
            s0_word     <= '0;
            s0_sub      <= '0;
            texel_valid <= 1'b0;
            texel_q     <= '0;
        end else begin
            s0_valid <= bus.texelValid;
            if (bus.texelValid) begin
                s0_bank <= active_bank;
                s0_word <= req_word;
                s0_sub  <= req_sub;
            end
            texel_valid <= s0_valid;
            if (s0_valid)
                texel_q <= rd_pixel;
        end
    end
endmodule

// File: tb/tb_texture_buffer_db.sv
// Randomized scoreboard bench for texture_buffer_db with a pixel-array reference model.
`timescale 1ns/1ps
module tb_texture_buffer_db;
    localparam int SW         = 32;
    localparam int BANK_PIX   = 8192;
    localparam int BANK_WORDS = 4096;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    texture_buffer_db_if #(.STREAM_WIDTH(SW)) bus();

    texture_buffer_db #(.STREAM_WIDTH(SW), .SIZE(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: two pixel arrays plus the load/config state as seen by a user.
    logic [15:0] mdl [2][BANK_PIX];
    int m_active, m_w, m_h, p_w, p_h, m_wc, pend_swap;
    bit m_cs, m_ct, p_cs, p_ct, m_first, m_ovf;

    function automatic void model_reset();
        m_active = 0; m_w = 5; m_h = 5; m_cs = 0; m_ct = 0;
        p_w = 5; p_h = 5; p_cs = 0; p_ct = 0;
        m_wc = 0; m_first = 1; m_ovf = 0; pend_swap = 0;
    endfunction

    function automatic int clampl(input logic [3:0] v);
        if (v < 5) return 5;
        if (v > 8) return 8;
        return int'(v);
    endfunction

    function automatic int axis_ref(input logic [15:0] c, input int n, input bit clamp);
        int v;
        v = int'($signed(c));
        if (clamp && v < 0) return 0;
        if (clamp && v >= 16384) return (1 << n) - 1;
        return ((v & 16383) * (1 << n)) / 16384;
    endfunction

    function automatic logic [15:0] ref_texel(input logic [15:0] s, input logic [15:0] t);
        int si, ti, addr;
        si   = axis_ref(s, m_w, m_cs);
        ti   = axis_ref(t, m_h, m_ct);
        addr = (ti * (1 << m_w) + si) % BANK_PIX;
        return mdl[m_active][addr];
    endfunction

    function automatic void model_beat(input logic [31:0] d, input bit last);
        int back;
        back = 1 - m_active;
        if (m_first) begin
            p_w = clampl(bus.confWidthLog2); p_h = clampl(bus.confHeightLog2);
            p_cs = bus.confClampS; p_ct = bus.confClampT;
        end
        if (m_wc < BANK_WORDS) begin
            mdl[back][2*m_wc]     = d[15:0];
            mdl[back][2*m_wc + 1] = d[31:16];
            m_wc++;
        end else begin
            m_ovf = 1;
        end
        if (last) begin m_wc = 0; m_first = 1; end
        else m_first = 0;
    endfunction

    // Scoreboard: expected texel and the cycle it must appear in.
    typedef struct { logic [15:0] val; int due; } exp_t;
    exp_t sbq[$];
    logic [15:0] last_exp = '0;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL texel_missing: no output, expected %0h due cycle %0d", sbq[0].val, sbq[0].due);
                void'(sbq.pop_front());
            end
            if (bus.texelOutValid) begin
                if (sbq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL texel_unexpected: got %0h with nothing expected (cycle %0d)", bus.texel, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("texel_cycle", cyc, e.due);
                    check("texel_value", bus.texel, e.val);
                    last_exp = e.val;
                end
            end else begin
                check("texel_hold", bus.texel, last_exp);
            end
        end
    end

    // One clock of stimulus; model updates and status checks after the edge.
    task automatic tick(input bit bv, input logic [31:0] d, input bit last,
                        input bit rq, input logic [15:0] s, input logic [15:0] t);
        bit swap_now;
        bus.s_axis_tvalid = bv;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        bus.texelValid    = rq;
        bus.texelS        = s;
        bus.texelT        = t;
        if (rq) sbq.push_back('{ref_texel(s, t), cyc + 2});
        if (bv) begin
            check("tready", bus.s_axis_tready, 1);
            model_beat(d, last);
        end
        @(posedge clk); #1;
        swap_now = 0;
        if (pend_swap == 1) begin
            m_active = 1 - m_active;
            m_w = p_w; m_h = p_h; m_cs = p_cs; m_ct = p_ct;
            pend_swap = 0;
            swap_now = 1;
        end
        if (bv && last) pend_swap = 1;
        check("loadDone", bus.loadDone, swap_now);
        check("activeBank", bus.activeBank, m_active);
        check("overflow", bus.overflow, m_ovf);
    endtask

    task automatic req(input logic [15:0] s, input logic [15:0] t);
        tick(0, '0, 0, 1, s, t);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, '0, 0, 0, '0, '0);
    endtask

    task automatic rand_st(output logic [15:0] s, output logic [15:0] t);
        if ($urandom_range(0, 1) == 0) begin
            s = 16'($urandom); t = 16'($urandom);
        end else begin
            s = 16'($urandom_range(0, 16'h4FFF)); t = 16'($urandom_range(0, 16'h4FFF));
        end
    endtask

    function automatic logic [31:0] beat_data(input int kind, input int b);
        logic [31:0] d;
        d = {16'(2*b + 1), 16'(2*b)};
        if (kind == 1) d = d ^ 32'h8000_8000;
        if (kind == 2) d = $urandom;
        return d;
    endfunction

    task automatic load_tex(input logic [3:0] w, input logic [3:0] h, input bit cs, input bit ct,
                            input int nbeats, input int kind, input int vpct, input int rpct);
        int b;
        bit bv, rq;
        logic [15:0] s, t;
        bus.confWidthLog2 = w; bus.confHeightLog2 = h;
        bus.confClampS = cs;   bus.confClampT = ct;
        b = 0;
        while (b < nbeats) begin
            bv = ($urandom_range(0, 99) < vpct);
            rq = ($urandom_range(0, 99) < rpct);
            rand_st(s, t);
            tick(bv, beat_data(kind, b), bv && (b == nbeats - 1), rq, s, t);
            if (bv) b++;
        end
        repeat (3) begin
            rq = ($urandom_range(0, 99) < rpct);
            rand_st(s, t);
            tick(0, '0, 0, rq, s, t);
        end
    endtask

    task automatic random_reads(input int n);
        logic [15:0] s, t;
        repeat (n) begin
            rand_st(s, t);
            tick(0, '0, 0, 1, s, t);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tready"}, bus.s_axis_tready, 0);
        check({tag, "_texelOutValid"}, bus.texelOutValid, 0);
        check({tag, "_texel"}, bus.texel, 0);
        check({tag, "_loadDone"}, bus.loadDone, 0);
        check({tag, "_overflow"}, bus.overflow, 0);
        check({tag, "_activeBank"}, bus.activeBank, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("tready_before_edge", bus.s_axis_tready, 0);
        @(posedge clk); #1;
        check("tready_after_edge", bus.s_axis_tready, 1);
    endtask

    initial begin
        reset = 1'b0;
        bus.confWidthLog2 = 4'd5; bus.confHeightLog2 = 4'd5;
        bus.confClampS = 1'b0;    bus.confClampT = 1'b0;
        bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0; bus.s_axis_tdata = '0;
        bus.texelValid = 1'b0;    bus.texelS = '0; bus.texelT = '0;
        model_reset();
        #1 reset = 1'b1;
        #1 check_reset_values("por");
        release_reset();

        // Texture A, 32x32 repeat, pixel = index
        load_tex(4'd5, 4'd5, 0, 0, 512, 0, 100, 0);
        req(16'h0200, 16'h0400);
        req(16'h5000, 16'h0000);
        idle(3);
        for (int k = 0; k < 10; k++) req(16'(k * 16'h0200), 16'h0000);
        idle(4);

        // Texture B streamed while sampling A every cycle
        load_tex(4'd5, 4'd5, 0, 0, 512, 1, 70, 100);
        random_reads(40);

        // A again with clamp S; out-of-range size fields clamp to 32x32
        load_tex(4'd3, 4'd0, 1, 0, 512, 0, 100, 0);
        req(16'h5000, 16'h0000);
        req(16'hC000, 16'h0000);
        req(16'h5000, 16'h5000);
        random_reads(30);

        // Overflow: 128x64 fills the bank exactly, four extra beats dropped
        load_tex(4'd7, 4'd6, 0, 0, BANK_WORDS + 4, 2, 100, 30);
        req(16'h3F00, 16'h3F00);
        req(16'h3F80, 16'h3F00);
        random_reads(100);

        // Reset in the middle of a load with reads in flight
        bus.confWidthLog2 = 4'd5; bus.confHeightLog2 = 4'd5;
        bus.confClampS = 1'b0;    bus.confClampT = 1'b0;
        for (int b = 0; b < 100; b++) begin
            logic [15:0] s, t;
            rand_st(s, t);
            tick(1, beat_data(0, b), 0, 1, s, t);
        end
        #2 reset = 1'b1;
        sbq.delete();
        last_exp = '0;
        model_reset();
        bus.s_axis_tvalid = 1'b0;
        bus.texelValid = 1'b0;
        #1 check_reset_values("abort");
        release_reset();

        // Fresh load after the abort
        load_tex(4'd5, 4'd5, 0, 0, 512, 0, 100, 0);
        req(16'h0200, 16'h0400);
        random_reads(20);
        idle(6);
        check("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
